// File: rtl/ld_frame_scheduler_pkg.sv
// Shared types and constants for the lane-detect frame scheduler.
package ld_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        STREAM,
        WAIT_RESULT
    } ld_sched_state_t;

    localparam int LD_IMG_WIDTH      = 416;
    localparam int LD_FRAME_ROWS     = 416;
    localparam int LD_TIMEOUT_CYCLES = 2**20;
    localparam int LD_CW             = $clog2(LD_IMG_WIDTH) + 1;

    localparam int ERR_TIMEOUT   = 0;
    localparam int ERR_ROW_LEN   = 1;
    localparam int ERR_EARLY_SOF = 2;
    localparam int ERR_W         = 3;

    typedef struct packed {
        logic [3:0]       lanes;
        logic [3:0]       cur_lane;
        logic [LD_CW-1:0] left;
        logic [LD_CW-1:0] right;
    } ld_result_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ld_frame_scheduler_watchdog.sv
// Cycle watchdog for the result wait: counts while run is high, flags the
// last permitted cycle on expired.
module ld_sched_watchdog #(
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = run && !clear && (count == LAST);

endmodule

// File: rtl/ld_frame_scheduler.sv
// Frame-level sequencer between the camera stream and LD_Wrapper.
// Optional build macro: LD_SCHED_BACKPRESSURE_EN (stall camera while waiting for a result).
module ld_frame_scheduler
    import ld_pkg::*;
#(
    parameter int IMG_WIDTH      = LD_IMG_WIDTH,
    parameter int FRAME_ROWS     = LD_FRAME_ROWS,
    parameter int TIMEOUT_CYCLES = LD_TIMEOUT_CYCLES,
    parameter int CW             = $clog2(IMG_WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cam_tvalid,
    input  logic             cam_tlast,
    input  logic             cam_tuser,
    output logic             cam_tready,
    output logic             pipe_tvalid,
    output logic             pipe_tlast,
    input  logic             pipe_tready,
    input  logic             ld_valid,
    input  logic [3:0]       ld_lanes,
    input  logic [3:0]       ld_cur_lane,
    input  logic [CW-1:0]    ld_left,
    input  logic [CW-1:0]    ld_right,
    output logic             res_valid,
    output logic [3:0]       res_lanes,
    output logic [3:0]       res_cur_lane,
    output logic [CW-1:0]    res_left,
    output logic [CW-1:0]    res_right,
    output logic             busy,
    output logic [15:0]      frame_count,
    output logic [15:0]      drop_count,
    output logic [ERR_W-1:0] err_flags
);
    localparam int RW = $clog2(FRAME_ROWS + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_ROWS - 1);
`ifdef LD_SCHED_BACKPRESSURE_EN
    localparam bit BACKPRESSURE = 1'b1;
`else
    localparam bit BACKPRESSURE = 1'b0;
`endif

    ld_sched_state_t  state, state_next;
    logic [CW-1:0]    col, col_next, base_col;
    logic [RW-1:0]    row, row_next, base_row;
    logic             pass, ready_int, cam_hs, fwd_hs;
    logic             set_err_row, set_err_sof, set_err_timeout;
    logic             take_result, drop_sof;
    logic             wd_clear, wd_run, wd_expired;
    logic [ERR_W-1:0] err_q;
    ld_result_t       result_q;

    ld_sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .run    (wd_run),
        .expired(wd_expired)
    );

    // Gating and beat accounting; the SOF beat counts from col/row 0.
    always_comb begin
        state_next      = state;
        pass            = 1'b0;
        ready_int       = 1'b1;
        col_next        = col;
        row_next        = row;
        set_err_row     = 1'b0;
        set_err_sof     = 1'b0;
        set_err_timeout = 1'b0;
        take_result     = 1'b0;
        drop_sof        = 1'b0;
        wd_run          = (state == WAIT_RESULT);
        wd_clear        = (state != WAIT_RESULT);

        case (state)
            IDLE: begin
                if (enable) state_next = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (!enable)        state_next = IDLE;
                else if (cam_tuser) pass = 1'b1;
            end
            STREAM: begin
                pass = 1'b1;
            end
            WAIT_RESULT: begin
                ready_int = !BACKPRESSURE;
            end
            default: state_next = IDLE;
        endcase

        if (pass) ready_int = pipe_tready;
        cam_hs   = cam_tvalid && ready_int;
        fwd_hs   = pass && cam_hs;
        base_col = (state == STREAM) ? col : '0;
        base_row = (state == STREAM) ? row : '0;

        if (fwd_hs) begin
            set_err_sof = (state == STREAM) && cam_tuser;
            state_next  = STREAM;
            if (cam_tlast) begin
                col_next    = '0;
                row_next    = base_row + 1'b1;
                set_err_row = (base_col != COL_LAST);
                if (base_row == ROW_LAST) state_next = WAIT_RESULT;
            end else begin
                col_next = base_col + 1'b1;
                row_next = base_row;
            end
        end

        if (state == WAIT_RESULT) begin
            drop_sof = !BACKPRESSURE && cam_hs && cam_tuser;
            if (ld_valid) begin
                take_result = 1'b1;
                state_next  = enable ? WAIT_SOF : IDLE;
            end else if (wd_expired) begin
                set_err_timeout = 1'b1;
                state_next      = WAIT_SOF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            col   <= col_next;
            row   <= row_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q       <= '0;
            result_q    <= '0;
            res_valid   <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            err_q[ERR_TIMEOUT]   <= err_q[ERR_TIMEOUT]   | set_err_timeout;
            err_q[ERR_ROW_LEN]   <= err_q[ERR_ROW_LEN]   | set_err_row;
            err_q[ERR_EARLY_SOF] <= err_q[ERR_EARLY_SOF] | set_err_sof;
            res_valid            <= take_result;
            if (take_result) begin
                result_q.lanes    <= ld_lanes;
                result_q.cur_lane <= ld_cur_lane;
                result_q.left     <= LD_CW'(ld_left);
                result_q.right    <= LD_CW'(ld_right);
                frame_count       <= frame_count + 16'd1;
            end
            if (drop_sof) drop_count <= sat_inc16(drop_count);
        end
    end

    // Camera sees no ready while the block is held in reset.
    assign cam_tready   = ready_int && rst_n;
    assign pipe_tvalid  = pass && cam_tvalid;
    assign pipe_tlast   = pass && cam_tlast;
    assign busy         = (state == STREAM) || (state == WAIT_RESULT);
    assign err_flags    = err_q;
    assign res_lanes    = result_q.lanes;
    assign res_cur_lane = result_q.cur_lane;
    assign res_left     = CW'(result_q.left);
    assign res_right    = CW'(result_q.right);

endmodule
